// File: rtl/axi_lite_ctrl_slave_if.sv
// AXI4-Lite bus bundle between the host master and the accelerator control slave.
// The clock and reset are kept outside the interface as plain module ports.
interface axi_lite_ctrl_slave_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/axi_lite_ctrl_slave.sv
// AXI4-Lite control/status register bank: one R/W CTRL register with a start pulse,
// plus read-only done flags and performance counters from the accelerator core.
module axi_lite_ctrl_slave #(
    parameter int PERF_CNTR_WIDTH = 32,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int AXIS_ADDR_WIDTH = 6
) (
    input  logic                       S_AXI_ACLK,
    input  logic                       S_AXI_ARESETN,
    axi_lite_ctrl_slave_if.slave       s_axi,
    output logic [AXIS_DATA_WIDTH-1:0] ctrl_reg,
    output logic                       start,
    input  logic                       tx_done,
    input  logic                       rd_done,
    input  logic                       wr_done,
    input  logic                       processing_done,
    input  logic [PERF_CNTR_WIDTH-1:0] total_cycles,
    input  logic [PERF_CNTR_WIDTH-1:0] rd_cycles,
    input  logic [PERF_CNTR_WIDTH-1:0] pr_cycles,
    input  logic [PERF_CNTR_WIDTH-1:0] wr_cycles
);
    localparam int IDX_W  = AXIS_ADDR_WIDTH - 2;
    localparam int STRB_W = AXIS_DATA_WIDTH / 8;

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_DATA } rstate_t;

    wstate_t                    wstate_q;
    rstate_t                    rstate_q;
    logic                       awready_q, wready_q, bvalid_q, start_q;
    logic                       arready_q, rvalid_q;
    logic [AXIS_DATA_WIDTH-1:0] ctrl_q, rdata_q;

    logic [AXIS_DATA_WIDTH-1:0] ctrl_merged;
    logic [AXIS_DATA_WIDTH-1:0] rd_mux;
    logic [IDX_W-1:0]           wr_idx, rd_idx;
    logic                       wr_fire, rd_fire;

    assign wr_idx  = s_axi.S_AXI_AWADDR[AXIS_ADDR_WIDTH-1:2];
    assign rd_idx  = s_axi.S_AXI_ARADDR[AXIS_ADDR_WIDTH-1:2];
    assign wr_fire = awready_q & wready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
    assign rd_fire = arready_q & s_axi.S_AXI_ARVALID;

    // Byte-lane merge of the incoming write data into the current CTRL value
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
        assign ctrl_merged[gi*8 +: 8] = s_axi.S_AXI_WSTRB[gi] ? s_axi.S_AXI_WDATA[gi*8 +: 8]
                                                              : ctrl_q[gi*8 +: 8];
    end

    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            IDX_W'(0): rd_mux = ctrl_q;
            IDX_W'(1): rd_mux = AXIS_DATA_WIDTH'(tx_done);
            IDX_W'(2): rd_mux = AXIS_DATA_WIDTH'(rd_done);
            IDX_W'(3): rd_mux = AXIS_DATA_WIDTH'({processing_done, wr_done});
            IDX_W'(4): rd_mux = AXIS_DATA_WIDTH'(total_cycles);
            IDX_W'(5): rd_mux = AXIS_DATA_WIDTH'(rd_cycles);
            IDX_W'(6): rd_mux = AXIS_DATA_WIDTH'(pr_cycles);
            IDX_W'(7): rd_mux = AXIS_DATA_WIDTH'(wr_cycles);
            default:   rd_mux = '0;
        endcase
    end

    // Write channel: ready pulses for one cycle only when AW and W are both presented
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            start_q   <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            start_q <= 1'b0;
            case (wstate_q)
                W_IDLE: begin
                    if (awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        if (wr_fire) begin
                            if (wr_idx == '0) begin
                                ctrl_q  <= ctrl_merged;
                                start_q <= s_axi.S_AXI_WSTRB[0] & s_axi.S_AXI_WDATA[0];
                            end
                            bvalid_q <= 1'b1;
                            wstate_q <= W_RESP;
                        end
                    end else if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        bvalid_q <= 1'b0;
                        wstate_q <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Read channel: RDATA is captured at the address handshake and held until RREADY
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (arready_q) begin
                        arready_q <= 1'b0;
                        if (rd_fire) begin
                            rdata_q  <= rd_mux;
                            rvalid_q <= 1'b1;
                            rstate_q <= R_DATA;
                        end
                    end else if (s_axi.S_AXI_ARVALID && !rvalid_q) begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi.S_AXI_RREADY) begin
                        rvalid_q <= 1'b0;
                        rstate_q <= R_IDLE;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = 2'b00;
    assign ctrl_reg            = ctrl_q;
    assign start               = start_q;

    logic unused_bits;
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_axi_lite_ctrl_slave.sv
// Directed and random bench for the AXI-Lite control slave; read expectations are
// queued when a read is issued and popped when RVALID is observed.
module tb_axi_lite_ctrl_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_lite_ctrl_slave_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

    logic [31:0] ctrl_reg;
    logic        start;
    logic        tx_done, rd_done, wr_done, processing_done;
    logic [31:0] total_cycles, rd_cycles, pr_cycles, wr_cycles;

    axi_lite_ctrl_slave #(
        .PERF_CNTR_WIDTH(32),
        .AXIS_DATA_WIDTH(32),
        .AXIS_ADDR_WIDTH(6)
    ) dut (
        .S_AXI_ACLK      (clk),
        .S_AXI_ARESETN   (rst_n),
        .s_axi           (bus),
        .ctrl_reg        (ctrl_reg),
        .start           (start),
        .tx_done         (tx_done),
        .rd_done         (rd_done),
        .wr_done         (wr_done),
        .processing_done (processing_done),
        .total_cycles    (total_cycles),
        .rd_cycles       (rd_cycles),
        .pr_cycles       (pr_cycles),
        .wr_cycles       (wr_cycles)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] sb_q[$];
    logic [31:0] ctrl_m;
    logic        s_pre, s_hs, s_after;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // stall > 0 holds BREADY low and presents a second AW/W that must not be accepted
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int stall);
        int n;
        @(negedge clk);
        bus.S_AXI_AWADDR = a; bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && n < 20);
        chk("aw_w_ready", 32'(bus.S_AXI_AWREADY && bus.S_AXI_WREADY), 32'd1);
        chk("aw_w_latency", 32'(n), 32'd1);
        s_pre = start;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        s_hs = start;
        chk("bvalid_set", 32'(bus.S_AXI_BVALID), 32'd1);
        chk("bresp", 32'(bus.S_AXI_BRESP), 32'd0);
        if (stall > 0) begin
            bus.S_AXI_WDATA = ~d; bus.S_AXI_WSTRB = 4'hF;
            bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("bvalid_hold", 32'(bus.S_AXI_BVALID), 32'd1);
            chk("awready_blocked", 32'(bus.S_AXI_AWREADY), 32'd0);
        end
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        s_after = start;
        chk("bvalid_clear", 32'(bus.S_AXI_BVALID), 32'd0);
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] exp, input int stall,
                            input bit finish_it);
        int n;
        logic [31:0] e;
        @(negedge clk);
        bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1;
        sb_q.push_back(exp);
        n = 0;
        do begin @(negedge clk); n++; end
        while (!bus.S_AXI_ARREADY && n < 20);
        chk("ar_ready", 32'(bus.S_AXI_ARREADY), 32'd1);
        chk("ar_latency", 32'(n), 32'd1);
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        chk("rvalid_set", 32'(bus.S_AXI_RVALID), 32'd1);
        e = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
        $display("read addr=0x%02h rdata=0x%08h expected=0x%08h", a, bus.S_AXI_RDATA, e);
        chk("rdata", bus.S_AXI_RDATA, e);
        chk("rresp", 32'(bus.S_AXI_RRESP), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("rvalid_hold", 32'(bus.S_AXI_RVALID), 32'd1);
            chk("rdata_hold", bus.S_AXI_RDATA, e);
        end
        if (finish_it) begin
            bus.S_AXI_RREADY = 1'b1;
            @(negedge clk);
            bus.S_AXI_RREADY = 1'b0;
            chk("rvalid_clear", 32'(bus.S_AXI_RVALID), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        tx_done = 1'b0; rd_done = 1'b0; wr_done = 1'b0; processing_done = 1'b0;
        total_cycles = '0; rd_cycles = '0; pr_cycles = '0; wr_cycles = '0;
        ctrl_m = '0;

        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
        chk("rst_wready", 32'(bus.S_AXI_WREADY), 32'd0);
        chk("rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
        chk("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
        chk("rst_rvalid", 32'(bus.S_AXI_RVALID), 32'd0);
        chk("rst_rdata", bus.S_AXI_RDATA, 32'd0);
        chk("rst_ctrl", ctrl_reg, 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        rst_n = 1'b1;

        // full-word write and readback
        axi_write(6'h00, 32'hDEADBEEF, 4'hF, 0);
        $display("write addr=0x00 data=0xDEADBEEF strb=0xF");
        chk("ctrl_reg_full", ctrl_reg, 32'hDEADBEEF);
        axi_read(6'h00, 32'hDEADBEEF, 0, 1'b1);
        chk("start_idle", 32'(start), 32'd0);

        // byte strobes: bytes 0 and 2 only, byte 0 has bit0 clear so no start
        axi_write(6'h00, 32'h11223344, 4'h5, 0);
        $display("write addr=0x00 data=0x11223344 strb=0x5");
        chk("strb_no_start", 32'(s_hs), 32'd0);
        axi_read(6'h00, 32'hDE22BE44, 0, 1'b1);

        // start pulse lasts exactly one cycle after the handshake
        axi_write(6'h00, 32'h00000001, 4'hF, 0);
        $display("write addr=0x00 data=0x00000001 strb=0xF start=%0b%0b%0b", s_pre, s_hs, s_after);
        chk("start_before", 32'(s_pre), 32'd0);
        chk("start_pulse", 32'(s_hs), 32'd1);
        chk("start_after", 32'(s_after), 32'd0);
        axi_read(6'h00, 32'h00000001, 0, 1'b1);

        // status and counters
        tx_done = 1'b1; wr_done = 1'b1; processing_done = 1'b0; rd_done = 1'b0;
        total_cycles = 32'h1234; rd_cycles = 32'hA5A5_0001; pr_cycles = 32'h7; wr_cycles = 32'hFFFF_FFFF;
        axi_read(6'h04, 32'h1, 0, 1'b1);
        axi_read(6'h08, 32'h0, 0, 1'b1);
        axi_read(6'h0C, 32'h1, 0, 1'b1);
        axi_read(6'h10, 32'h1234, 0, 1'b1);
        axi_read(6'h14, 32'hA5A5_0001, 0, 1'b1);
        axi_read(6'h1C, 32'hFFFF_FFFF, 0, 1'b1);
        axi_read(6'h24, 32'h0, 0, 1'b1);
        axi_read(6'h3C, 32'h0, 0, 1'b1);
        processing_done = 1'b1; wr_done = 1'b0;
        axi_read(6'h0C, 32'h2, 0, 1'b1);
        axi_write(6'h10, 32'hCAFEF00D, 4'hF, 0);
        $display("write addr=0x10 data=0xCAFEF00D strb=0xF");
        axi_read(6'h10, 32'h1234, 0, 1'b1);
        chk("ctrl_after_ro_write", ctrl_reg, 32'h00000001);

        // back-pressure on both channels, with a second write pending during the B stall
        axi_write(6'h00, 32'h5A5A_0F0E, 4'hF, 5);
        $display("write addr=0x00 data=0x5A5A0F0E strb=0xF stalled=5");
        chk("ctrl_second_blocked", ctrl_reg, 32'h5A5A_0F0E);
        axi_read(6'h00, 32'h5A5A_0F0E, 5, 1'b1);

        // CTRL read and write handshaking on the same edge: read sees the old value
        fork
            axi_write(6'h00, 32'h0BAD_CAFE, 4'hF, 0);
            axi_read(6'h00, 32'h5A5A_0F0E, 0, 1'b1);
        join
        $display("write addr=0x00 data=0x0BADCAFE concurrent with read");
        axi_read(6'h00, 32'h0BAD_CAFE, 0, 1'b1);

        // reset during an outstanding read
        axi_read(6'h00, 32'h0BAD_CAFE, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rvalid", 32'(bus.S_AXI_RVALID), 32'd0);
        chk("rst_mid_ctrl", ctrl_reg, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_rvalid", 32'(bus.S_AXI_RVALID), 32'd0);
        chk("post_rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
        axi_read(6'h00, 32'h0, 0, 1'b1);

        // random write/read pairs to CTRL
        for (int k = 0; k < 200; k++) begin
            d = $urandom;
            axi_write(6'h00, d, 4'hF, 0);
            ctrl_m = d;
            $display("write addr=0x00 data=0x%08h strb=0xF", d);
            axi_read(6'h00, ctrl_m, 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_lite_ctrl_slave.md
Name: axi_lite_ctrl_slave

Overview:
- AXI4-Lite slave register bank for accelerator control and status; the host/testbench AXI-Lite master drives it.
- Holds a read/write control/scratch register and issues a start pulse to the accelerator core.
- Exposes done flags and performance counters from the core as read-only registers.

Parameters:
- PERF_CNTR_WIDTH, 32, width of each performance counter input (must be <= AXIS_DATA_WIDTH; zero-extended on read).
- AXIS_DATA_WIDTH, 32, AXI-Lite data width (32 only).
- AXIS_ADDR_WIDTH, 6, AXI-Lite byte address width; word index = addr[AXIS_ADDR_WIDTH-1:2].

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  AXIS_ADDR_WIDTH  write address (byte).
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  write address handshake.
- S_AXI_WDATA  in  AXIS_DATA_WIDTH  write data.
- S_AXI_WSTRB  in  AXIS_DATA_WIDTH/8  byte strobes.
- S_AXI_WVALID/S_AXI_WREADY  in/out  1  write data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID/S_AXI_BREADY  out/in  1  write response handshake.
- S_AXI_ARADDR  in  AXIS_ADDR_WIDTH  read address (byte).
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  read address handshake.
- S_AXI_RDATA  out  AXIS_DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID/S_AXI_RREADY  out/in  1  read data handshake.
- ctrl_reg  out  AXIS_DATA_WIDTH  current value of CTRL.
- start  out  1  one-cycle pulse on a CTRL write with WDATA[0]=1 and WSTRB[0]=1.
- tx_done, rd_done, wr_done, processing_done  in  1 each  core status levels.
- total_cycles, rd_cycles, pr_cycles, wr_cycles  in  PERF_CNTR_WIDTH each  core counters.

Behaviour:
- Register map (word index): 0 CTRL (R/W); 1 {31'b0,tx_done}; 2 {31'b0,rd_done}; 3 {30'b0,processing_done,wr_done}; 4 total_cycles; 5 rd_cycles; 6 pr_cycles; 7 wr_cycles; 8-15 read 0.
- Writes to indices 1-15 are discarded but still return OKAY. Status and counter inputs are sampled at the read capture edge; there is no extra synchronisation.
- Reset (async assert, value held while low): all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, CTRL 0, start 0.
- Write FSM (W_IDLE, W_RESP):
  - In W_IDLE, when AWVALID & WVALID & !AWREADY, assert AWREADY and WREADY for exactly one cycle.
  - On the edge where both READY and both VALID are high: apply WDATA to CTRL bytewise per WSTRB, pulse start the following cycle if applicable, set BVALID, move to W_RESP.
  - In W_RESP, hold BVALID until BREADY, then return to W_IDLE. No new AW/W is accepted while BVALID=1.
  - AW without W (or W without AW) waits with READY low.
- Read FSM (R_IDLE, R_DATA):
  - In R_IDLE, when ARVALID & !ARREADY & !RVALID, assert ARREADY for one cycle.
  - On the handshake edge, latch the word index, set RVALID, and load RDATA with the mux output.
  - RDATA/RVALID are held stable until RREADY; clear RVALID on the edge where RVALID & RREADY, then return to R_IDLE.
- Latency: AWVALID+WVALID to BVALID is 2 edges; ARVALID to RVALID is 2 edges. One transaction per channel in flight.
- Read and write channels are independent. A CTRL read handshaking on the same edge as a CTRL write returns the pre-write value.
- Reset mid-transaction aborts it; no B/R is issued after reset release.

Test Plan:
- Write 0xDEADBEEF to 0x00 with WSTRB=0xF, then read 0x00 -> RDATA=0xDEADBEEF, BRESP=RRESP=0, ctrl_reg=0xDEADBEEF, start=0.
- Write 0x00000001 to 0x00 -> start high for exactly 1 cycle, the cycle after the W handshake; a read returns 0x00000001.
- CTRL=0xDEADBEEF, then write 0x11223344 with WSTRB=0x5 -> read returns 0xDE22BE44.
- tx_done=1, wr_done=1, processing_done=0, total_cycles=0x1234 -> reads at 0x04, 0x0C, 0x10 return 0x1, 0x1, 0x1234; read 0x24 returns 0; write to 0x10 leaves it at 0x1234.
- Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and RDATA stay stable; a second AW/W is not accepted until B completes.
- Assert ARESETN low during an outstanding read -> RVALID drops immediately, CTRL=0; after release a new read of 0x00 returns 0.
- 200 random write/read pairs to 0x00 -> every readback equals the written value.
